// File: rtl/ecp5pll_pkg.sv
// ecp5pll_pkg
//   Types and constants shared by the ECP5 PLL helper blocks: the dynamic
//   phase sequencer state encoding and the EHXPLLL PFD/VCO operating limits
//   used by the clock-generator family.
package ecp5pll_pkg;

  // Dynamic phase shift sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_SETTLE,
    ST_DONE
  } phase_state_e;

  // EHXPLLL operating limits (Hz).
  localparam int unsigned PFD_MIN_HZ = 32'd3_125_000;
  localparam int unsigned PFD_MAX_HZ = 32'd400_000_000;
  localparam int unsigned VCO_MIN_HZ = 32'd400_000_000;
  localparam int unsigned VCO_MAX_HZ = 32'd800_000_000;

  // One phasestep pulse moves an output by 1/8 of a VCO period.
  localparam int unsigned PHASE_STEPS_PER_VCO = 32'd8;

  // Width of a down-counter that must hold max(a, b) - 1, never below 1 bit.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ecp5pll_phase_dist.sv
// ecp5pll_phase_dist
//   Shortest-path distance between the tracked phase of a PLL output and a
//   requested phase on a circular scale of `modulus` positions.
//   Ports:
//     cur      - current tracked phase
//     target   - requested phase (caller guarantees target < modulus)
//     modulus  - wrap modulus (output_div * 8)
//     dir      - 0 = step up, 1 = step down
//     steps    - number of phasestep pulses needed (0 when already there)
module ecp5pll_phase_dist #(
  parameter int PHASE_W = 10
) (
  input  logic [PHASE_W-1:0] cur,
  input  logic [PHASE_W-1:0] target,
  input  logic [PHASE_W-1:0] modulus,
  output logic               dir,
  output logic [PHASE_W-1:0] steps
);

  logic [PHASE_W:0] cur_x;
  logic [PHASE_W:0] tgt_x;
  logic [PHASE_W:0] mod_x;
  logic [PHASE_W:0] fwd;
  logic [PHASE_W:0] bwd;

  always_comb begin
    tgt_x = {1'b0, target};
    mod_x = {1'b0, modulus};
    // A channel tracked under a larger modulus may sit above the new one;
    // fold it back once so the circular difference stays in range.
    cur_x = {1'b0, cur};
    if (cur_x >= mod_x) begin
      cur_x = cur_x - mod_x;
    end

    if (tgt_x >= cur_x) begin
      fwd = tgt_x - cur_x;
    end else begin
      fwd = tgt_x + mod_x - cur_x;
    end
    bwd = mod_x - fwd;

    // Equal distance either way resolves to incrementing.
    if (fwd <= bwd) begin
      dir   = 1'b0;
      steps = PHASE_W'(fwd);
    end else begin
      dir   = 1'b1;
      steps = PHASE_W'(bwd);
    end
  end

endmodule

// File: rtl/ecp5pll_phase_seq.sv
// ecp5pll_phase_seq
//   Drives the EHXPLLL dynamic phase port (PHASESEL/PHASEDIR/PHASESTEP) to
//   move one PLL output to a requested phase, tracking the phase of every
//   output so each request only issues the shortest run of step pulses.
//
//   state  | meaning
//   IDLE   | ready for a request
//   SETUP  | phasesel/phasedir presented one cycle ahead of the first pulse
//   PULSE  | phasestep high for PULSE_CYCLES
//   SETTLE | phasestep low for SETTLE_CYCLES
//   DONE   | single-cycle done pulse, then back to IDLE
//
//   Ports:
//     clk_i, reset       - clock, synchronous active-high reset
//     req_valid/ready    - request handshake (ready only in IDLE)
//     req_ch/phase/mod   - target output, target phase, wrap modulus
//     phasesel/dir/step  - EHXPLLL dynamic phase controls
//     phaseloadreg       - tied low
//     busy, done, err    - status; done/err are one-cycle pulses
//     cur_phase          - tracked phase, channel n at [n*PHASE_W +: PHASE_W]
module ecp5pll_phase_seq
  import ecp5pll_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int PHASE_W       = 10,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                        clk_i,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [1:0]                  req_ch,
  input  logic [PHASE_W-1:0]          req_phase,
  input  logic [PHASE_W-1:0]          req_mod,
  output logic [1:0]                  phasesel,
  output logic                        phasedir,
  output logic                        phasestep,
  output logic                        phaseloadreg,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [CHANNELS*PHASE_W-1:0] cur_phase
);

  localparam int TW = timer_width(PULSE_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0] PULSE_LOAD  = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  phase_state_e       state;
  logic [PHASE_W-1:0] cur_q [CHANNELS];
  logic [PHASE_W-1:0] mod_q;
  logic [PHASE_W-1:0] steps_left;
  logic [TW-1:0]      timer;

  logic [PHASE_W-1:0] cur_req;
  logic [PHASE_W-1:0] cur_act;
  logic [PHASE_W-1:0] step_next;
  logic               req_bad;
  logic               dist_dir;
  logic [PHASE_W-1:0] dist_n;

  assign phaseloadreg = 1'b0;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
    assign cur_phase[g*PHASE_W +: PHASE_W] = cur_q[g];
  end

  // Phase of the requested channel and of the channel being stepped.
  always_comb begin
    cur_req = '0;
    cur_act = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (req_ch == 2'(c)) cur_req = cur_q[c];
      if (phasesel == 2'(c)) cur_act = cur_q[c];
    end
  end

  always_comb begin
    if (phasedir) begin
      step_next = (cur_act == '0) ? mod_q - PHASE_W'(1) : cur_act - PHASE_W'(1);
    end else begin
      step_next = (cur_act >= mod_q - PHASE_W'(1)) ? '0 : cur_act + PHASE_W'(1);
    end
  end

  assign req_bad = (req_mod == '0) || (req_phase >= req_mod) ||
                   ({1'b0, req_ch} >= 3'(CHANNELS));

  ecp5pll_phase_dist #(
    .PHASE_W (PHASE_W)
  ) u_dist (
    .cur     (cur_req),
    .target  (req_phase),
    .modulus (req_mod),
    .dir     (dist_dir),
    .steps   (dist_n)
  );

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      phasesel   <= '0;
      phasedir   <= 1'b0;
      phasestep  <= 1'b0;
      mod_q      <= '0;
      steps_left <= '0;
      timer      <= '0;
      for (int c = 0; c < CHANNELS; c++) cur_q[c] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              err <= 1'b1;
            end else begin
              phasesel   <= req_ch;
              phasedir   <= dist_dir;
              mod_q      <= req_mod;
              steps_left <= dist_n;
              req_ready  <= 1'b0;
              busy       <= 1'b1;
              if (dist_n == '0) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_SETUP;
              end
            end
          end
        end
        ST_SETUP: begin
          state     <= ST_PULSE;
          phasestep <= 1'b1;
          timer     <= PULSE_LOAD;
        end
        ST_PULSE: begin
          if (timer == '0) begin
            state      <= ST_SETTLE;
            phasestep  <= 1'b0;
            timer      <= SETTLE_LOAD;
            steps_left <= steps_left - PHASE_W'(1);
            for (int c = 0; c < CHANNELS; c++) begin
              if (phasesel == 2'(c)) cur_q[c] <= step_next;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_SETTLE: begin
          if (timer == '0) begin
            if (steps_left != '0) begin
              state     <= ST_PULSE;
              phasestep <= 1'b1;
              timer     <= PULSE_LOAD;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          phasestep <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecp5pll_phase_seq.sv
module tb_ecp5pll_phase_seq;

  localparam int CH = 4;
  localparam int PW = 10;
  localparam int PC = 4;
  localparam int SC = 16;

  logic               clk_i = 1'b0;
  logic               reset = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [1:0]         req_ch = '0;
  logic [PW-1:0]      req_phase = '0;
  logic [PW-1:0]      req_mod = '0;
  logic [1:0]         phasesel;
  logic               phasedir;
  logic               phasestep;
  logic               phaseloadreg;
  logic               busy;
  logic               done;
  logic               err;
  logic [CH*PW-1:0]   cur_phase;

  ecp5pll_phase_seq #(
    .CHANNELS(CH), .PHASE_W(PW), .PULSE_CYCLES(PC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk_i(clk_i), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_phase(req_phase), .req_mod(req_mod),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .phaseloadreg(phaseloadreg), .busy(busy), .done(done), .err(err),
    .cur_phase(cur_phase)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit is_err;
    bit dir;
    int sel;
    int pulses;
    int done_at;
    int final_phase;
  } exp_t;

  exp_t exp_q[$];
  int   model_cur[CH];
  int   traj_q[$];

  // observed results of the last collect
  int o_pulses, o_busy, o_done_at, o_err_at, o_sel;
  bit o_dir, o_stable, o_timeout;

  function automatic logic [CH*PW-1:0] model_vec();
    logic [CH*PW-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) v[c*PW +: PW] = PW'(model_cur[c]);
    return v;
  endfunction

  // Drive one request and push its expected outcome from the bench model.
  task automatic send(input int ch, input int ph, input int md);
    exp_t e;
    int fwd, bwd, n;
    @(negedge clk_i);
    req_valid = 1'b1;
    req_ch    = 2'(ch);
    req_phase = PW'(ph);
    req_mod   = PW'(md);
    e.sel = ch;
    if (md == 0 || ph >= md || ch >= CH) begin
      e.is_err = 1; e.dir = 0; e.pulses = 0; e.done_at = 0;
      e.final_phase = model_cur[ch];
    end else begin
      fwd = ((ph - model_cur[ch]) % md + md) % md;
      bwd = md - fwd;
      e.is_err = 0;
      if (fwd <= bwd) begin e.dir = 0; n = fwd; end
      else begin e.dir = 1; n = bwd; end
      e.pulses = n;
      e.done_at = (n == 0) ? 1 : 2 + n * (PC + SC);
      e.final_phase = ph;
      model_cur[ch] = ph;
    end
    exp_q.push_back(e);
    for (int i = 0; i < 3000 && req_ready !== 1'b1; i++) @(negedge clk_i);
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL send_ready: req_ready=%b required 1", req_ready);
    end
    @(posedge clk_i);
    #1 req_valid = 1'b0;
  endtask

  // Observe the DUT cycle by cycle from T+1 until the request completes.
  task automatic collect();
    int cyc;
    bit prev, first;
    cyc = 0; prev = 0; first = 1;
    o_pulses = 0; o_busy = 0; o_done_at = 0; o_err_at = 0; o_sel = 0;
    o_dir = 0; o_stable = 1; o_timeout = 0;
    traj_q.delete();
    while (1) begin
      @(negedge clk_i);
      cyc++;
      if (busy) begin
        o_busy++;
        if (first) begin o_sel = int'(phasesel); o_dir = phasedir; first = 0; end
        else if (int'(phasesel) != o_sel || phasedir != o_dir) o_stable = 0;
      end
      if (phasestep && !prev) o_pulses++;
      if (!phasestep && prev) traj_q.push_back(int'(cur_phase[phasesel*PW +: PW]));
      prev = phasestep;
      if (done && o_done_at == 0) o_done_at = cyc;
      if (err && o_err_at == 0) o_err_at = cyc;
      if ((o_done_at != 0 || o_err_at != 0) && !busy) break;
      if (cyc >= 3000) begin o_timeout = 1; break; end
    end
  endtask

  // phasestep run-length monitor: every high run and every inter-pulse gap.
  int hi_run = 0, lo_run = 0;
  bit have_pulse = 0, prev_ps = 0;
  always @(negedge clk_i) begin
    if (reset) begin
      hi_run = 0; lo_run = 0; have_pulse = 0; prev_ps = 0;
    end else begin
      if (phasestep) begin
        if (!prev_ps) begin
          if (have_pulse) begin
            checks++;
            if (lo_run != SC) begin
              failures++;
              $display("FAIL settle_gap: low for %0d cycles, required %0d", lo_run, SC);
            end
          end
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev_ps) begin
          checks++;
          if (hi_run != PC) begin
            failures++;
            $display("FAIL pulse_width: high for %0d cycles, required %0d", hi_run, PC);
          end
          have_pulse = 1;
          lo_run = 0;
        end
        lo_run++;
        if (!busy) have_pulse = 0;
      end
      prev_ps = phasestep;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_i);
    // valid request held during reset must be ignored
    req_valid = 1'b1; req_ch = 2'd1; req_phase = PW'(5); req_mod = PW'(40);
    @(negedge clk_i);
    checks++;
    if ({req_ready, busy, done, err, phasestep, phasedir, phaseloadreg} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctrl: {ready,busy,done,err,step,dir,load}=%b required 1000000",
               {req_ready, busy, done, err, phasestep, phasedir, phaseloadreg});
    end
    checks++;
    if (phasesel !== 2'd0 || cur_phase !== '0) begin
      failures++;
      $display("FAIL reset_state: phasesel=%0d cur_phase=%h required 0/0", phasesel, cur_phase);
    end
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk_i);
    checks++;
    if (busy !== 1'b0 || cur_phase !== '0) begin
      failures++;
      $display("FAIL reset_dominates: busy=%b cur_phase=%h required 0/0", busy, cur_phase);
    end
  endtask

  task automatic test_inc();
    exp_t e;
    send(1, 3, 40);
    collect();
    e = exp_q.pop_front();
    checks++;
    if (o_timeout) begin failures++; $display("FAIL inc_timeout: no done within budget"); end
    checks++;
    if (o_pulses != e.pulses || o_dir != e.dir || o_sel != e.sel) begin
      failures++;
      $display("FAIL inc_steps: pulses=%0d dir=%0d sel=%0d required %0d/%0d/%0d",
               o_pulses, o_dir, o_sel, e.pulses, e.dir, e.sel);
    end
    checks++;
    if (o_done_at != e.done_at || o_busy != e.done_at) begin
      failures++;
      $display("FAIL inc_latency: done_at=%0d busy=%0d required %0d", o_done_at, o_busy, e.done_at);
    end
    checks++;
    if (!o_stable) begin failures++; $display("FAIL inc_stable: sel/dir changed while busy, required constant"); end
    checks++;
    if (cur_phase !== model_vec()) begin
      failures++;
      $display("FAIL inc_cur: cur_phase=%h required %h", cur_phase, model_vec());
    end
  endtask

  task automatic test_dec();
    exp_t e;
    int c;
    send(0, 2, 40);
    collect();
    e = exp_q.pop_front();
    checks++;
    if (o_pulses != e.pulses || o_dir != e.dir || cur_phase !== model_vec()) begin
      failures++;
      $display("FAIL dec_prep: pulses=%0d dir=%0d required %0d/%0d", o_pulses, o_dir, e.pulses, e.dir);
    end
    c = model_cur[0];
    send(0, 38, 40);
    collect();
    e = exp_q.pop_front();
    checks++;
    if (o_pulses != e.pulses || o_dir != e.dir || o_sel != e.sel || o_done_at != e.done_at) begin
      failures++;
      $display("FAIL dec_steps: pulses=%0d dir=%0d sel=%0d done_at=%0d required %0d/%0d/%0d/%0d",
               o_pulses, o_dir, o_sel, o_done_at, e.pulses, e.dir, e.sel, e.done_at);
    end
    checks++;
    if (traj_q.size() != e.pulses) begin
      failures++;
      $display("FAIL dec_traj_len: %0d steps seen, required %0d", traj_q.size(), e.pulses);
    end else begin
      for (int i = 0; i < e.pulses; i++) begin
        c = (c == 0) ? 39 : c - 1;
        checks++;
        if (traj_q[i] != c) begin
          failures++;
          $display("FAIL dec_traj[%0d]: cur=%0d required %0d", i, traj_q[i], c);
        end
      end
    end
  endtask

  task automatic test_tie();
    exp_t e;
    send(3, 20, 40);
    collect();
    e = exp_q.pop_front();
    checks++;
    if (o_pulses != 20 || o_dir != 1'b0 || e.pulses != 20 || cur_phase !== model_vec()) begin
      failures++;
      $display("FAIL tie_up: pulses=%0d dir=%0d cur=%h required 20/0/%h", o_pulses, o_dir, cur_phase, model_vec());
    end
    send(3, 0, 40);
    collect();
    e = exp_q.pop_front();
    checks++;
    if (o_pulses != e.pulses || o_dir != e.dir) begin
      failures++;
      $display("FAIL tie_wrap_steps: pulses=%0d dir=%0d required %0d/%0d", o_pulses, o_dir, e.pulses, e.dir);
    end
    checks++;
    if (traj_q.size() != 20 || traj_q[18] != 39 || traj_q[19] != 0) begin
      failures++;
      $display("FAIL tie_wrap: last steps wrong (size=%0d), required ...39,0", traj_q.size());
    end
  endtask

  task automatic test_err_and_zero();
    exp_t e;
    send(1, 40, 40);
    collect();
    e = exp_q.pop_front();
    checks++;
    if (o_err_at != 1 || o_done_at != 0 || o_pulses != 0 || !e.is_err) begin
      failures++;
      $display("FAIL err_range: err_at=%0d done_at=%0d pulses=%0d required 1/0/0", o_err_at, o_done_at, o_pulses);
    end
    checks++;
    if (cur_phase !== model_vec()) begin
      failures++;
      $display("FAIL err_cur: cur_phase=%h required %h", cur_phase, model_vec());
    end
    send(2, 0, 0);
    collect();
    e = exp_q.pop_front();
    checks++;
    if (o_err_at != 1 || o_busy != 0 || cur_phase !== model_vec()) begin
      failures++;
      $display("FAIL err_mod0: err_at=%0d busy=%0d required 1/0", o_err_at, o_busy);
    end
    send(1, 3, 40);
    collect();
    e = exp_q.pop_front();
    checks++;
    if (o_done_at != e.done_at || o_pulses != 0 || o_busy != 1 || o_err_at != 0) begin
      failures++;
      $display("FAIL zero_dist: done_at=%0d pulses=%0d busy=%0d err_at=%0d required %0d/0/1/0",
               o_done_at, o_pulses, o_busy, o_err_at, e.done_at);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    send(2, 2, 40);
    fork
      collect();
      send(2, 38, 40);
    join
    e = exp_q.pop_front();
    checks++;
    if (o_pulses != e.pulses || o_dir != e.dir || !o_stable || o_sel != 2) begin
      failures++;
      $display("FAIL b2b_first: pulses=%0d dir=%0d stable=%0d required %0d/%0d/1",
               o_pulses, o_dir, o_stable, e.pulses, e.dir);
    end
    collect();
    e = exp_q.pop_front();
    checks++;
    if (o_pulses != e.pulses || o_dir != e.dir || o_done_at != e.done_at || cur_phase !== model_vec()) begin
      failures++;
      $display("FAIL b2b_second: pulses=%0d dir=%0d done_at=%0d required %0d/%0d/%0d",
               o_pulses, o_dir, o_done_at, e.pulses, e.dir, e.done_at);
    end
  endtask

  task automatic test_reset_mid_pulse();
    exp_t e;
    int rises;
    bit prev;
    send(2, 3, 40);
    e = exp_q.pop_front();
    rises = 0; prev = 0;
    for (int i = 0; i < 500 && rises < 2; i++) begin
      @(negedge clk_i);
      if (phasestep && !prev) rises++;
      prev = phasestep;
    end
    checks++;
    if (rises != 2 || e.pulses != 5) begin
      failures++;
      $display("FAIL midrst_reach: rises=%0d planned=%0d required 2/5", rises, e.pulses);
    end
    reset = 1'b1;
    @(negedge clk_i);
    checks++;
    if (phasestep !== 1'b0 || cur_phase !== '0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_state: step=%b cur=%h ready=%b busy=%b required 0/0/1/0",
               phasestep, cur_phase, req_ready, busy);
    end
    @(negedge clk_i);
    reset = 1'b0;
    for (int c = 0; c < CH; c++) model_cur[c] = 0;
    send(2, 1, 40);
    collect();
    e = exp_q.pop_front();
    checks++;
    if (o_pulses != e.pulses || o_dir != e.dir || cur_phase !== model_vec()) begin
      failures++;
      $display("FAIL midrst_after: pulses=%0d dir=%0d cur=%h required %0d/%0d/%h",
               o_pulses, o_dir, cur_phase, e.pulses, e.dir, model_vec());
    end
  endtask

  initial begin
    for (int c = 0; c < CH; c++) model_cur[c] = 0;
    test_reset();
    test_inc();
    test_dec();
    test_tie();
    test_err_and_zero();
    test_back_to_back();
    test_reset_mid_pulse();
    repeat (4) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
